// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants and checker state type
package lfsr_pkg;

    localparam int                    LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 4'b1100;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - serial bit input and status outputs of lfsr_checker (LFSR_CHECKER_STICKY_EN adds err_sticky)
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);

    logic             bit_valid;
    logic             bit_in;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             led;

`ifdef LFSR_CHECKER_STICKY_EN
    logic             err_sticky;

    modport master (
        output bit_valid, bit_in,
        input  locked, err_pulse, err_count, led, err_sticky
    );

    modport slave (
        input  bit_valid, bit_in,
        output locked, err_pulse, err_count, led, err_sticky
    );
`else
    modport master (
        output bit_valid, bit_in,
        input  locked, err_pulse, err_count, led
    );

    modport slave (
        input  bit_valid, bit_in,
        output locked, err_pulse, err_count, led
    );
`endif

endinterface

// File: rtl/lfsr_predict.sv
// rtl/lfsr_predict.sv - Fibonacci LFSR feedback bit, shared by generator and checker
module lfsr_predict #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] state,
    output logic             pred
);

    assign pred = ^(state & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with lock detect and error counting
// Optional: define LFSR_CHECKER_STICKY_EN for the err_sticky output gating the LED.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS,
    parameter int               LOCK_COUNT  = 15,
    parameter int               WINDOW      = 16,
    parameter int               LOSS_THRESH = 4,
    parameter int               CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);

    localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [WW-1:0] THRESH    = WW'(LOSS_THRESH);

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d, shift_in;
    logic [SW-1:0]    seed_cnt, seed_cnt_d;
    logic [MW-1:0]    match_cnt, match_cnt_d;
    logic [WW-1:0]    win_cnt, win_cnt_d;
    logic [WW-1:0]    win_err, win_err_d, win_err_inc;
    logic             err_pulse, err_pulse_d;
    logic [CNT_W-1:0] err_count, err_count_d;
    logic             pred;
    logic             mismatch;
    logic             locked;

    lfsr_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .state (shreg),
        .pred  (pred)
    );

    assign mismatch    = bus.bit_in != pred;
    assign shift_in    = {shreg[WIDTH-2:0], bus.bit_in};
    assign win_err_inc = win_err + WW'(mismatch);
    assign locked      = state == LOCKED;

    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        seed_cnt_d  = seed_cnt;
        match_cnt_d = match_cnt;
        win_cnt_d   = win_cnt;
        win_err_d   = win_err;
        err_pulse_d = 1'b0;
        err_count_d = err_count;
        if (bus.bit_valid) begin
            case (state)
                SEED: begin
                    shreg_d    = shift_in;
                    seed_cnt_d = seed_cnt + SW'(1);
                    if (seed_cnt == SEED_LAST) begin
                        // An all-zero load is the LFSR lock-up state; keep reloading.
                        seed_cnt_d = '0;
                        if (shift_in != '0) begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_d     = SEED;
                        match_cnt_d = '0;
                        seed_cnt_d  = '0;
                    end else begin
                        shreg_d     = shift_in;
                        match_cnt_d = match_cnt + MW'(1);
                        if (match_cnt == LOCK_LAST) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            win_cnt_d   = '0;
                            win_err_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-running reference: received errors never enter the register.
                    shreg_d     = {shreg[WIDTH-2:0], pred};
                    err_pulse_d = mismatch;
                    if (mismatch && (err_count != '1)) begin
                        err_count_d = err_count + CNT_W'(1);
                    end
                    win_cnt_d = win_cnt + WW'(1);
                    win_err_d = win_err_inc;
                    if (win_cnt == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_inc >= THRESH) begin
                            state_d    = SEED;
                            seed_cnt_d = '0;
                        end
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEED;
            shreg     <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            shreg     <= shreg_d;
            seed_cnt  <= seed_cnt_d;
            match_cnt <= match_cnt_d;
            win_cnt   <= win_cnt_d;
            win_err   <= win_err_d;
            err_pulse <= err_pulse_d;
            err_count <= err_count_d;
        end
    end

    assign bus.locked    = locked;
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;

`ifdef LFSR_CHECKER_STICKY_EN
    logic err_sticky;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
        end else if (bus.bit_valid && locked && mismatch) begin
            err_sticky <= 1'b1;
        end
    end

    assign bus.err_sticky = err_sticky;
    assign bus.led        = locked & ~err_sticky;
`else
    assign bus.led        = locked;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized self-checking bench for lfsr_checker against a bit-history model
module tb_lfsr_checker;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

    lfsr_checker #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Generator: period-15 sequence from x^4+x^3+1
    logic [3:0] g;

    task automatic gen_bit(output bit b);
        b = g[3] ^ g[2];
        g = {g[2:0], b};
    endtask

    // Reference model: mode 0 collecting seed, 1 verifying, 2 locked
    int m_mode, m_n, m_wcnt, m_werr, m_cnt;
    bit m_pulse, m_sticky;
    bit m_hist[$];

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_wcnt = 0; m_werr = 0; m_cnt = 0;
        m_pulse = 0; m_sticky = 0;
        m_hist = {1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_bit(input bit b);
        bit p;
        p = m_hist[0] ^ m_hist[1];
        m_pulse = 0;
        if (m_mode == 0) begin
            m_hist.push_back(b);
            void'(m_hist.pop_front());
            m_n++;
            if (m_n == 4) begin
                m_n = 0;
                if ((m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]) != 0) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (b != p) begin
                m_mode = 0;
                m_n = 0;
            end else begin
                m_hist.push_back(b);
                void'(m_hist.pop_front());
                m_n++;
                if (m_n == 15) begin
                    m_mode = 2; m_n = 0; m_wcnt = 0; m_werr = 0;
                end
            end
        end else begin
            m_hist.push_back(p);
            void'(m_hist.pop_front());
            if (b != p) begin
                m_pulse = 1;
                m_sticky = 1;
                m_werr++;
                if (m_cnt < 65535) m_cnt++;
            end
            m_wcnt++;
            if (m_wcnt == 16) begin
                if (m_werr >= 4) begin
                    m_mode = 0;
                    m_n = 0;
                end
                m_wcnt = 0;
                m_werr = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("locked", 32'(bus.locked), 32'(m_mode == 2));
        check("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        check("err_count", 32'(bus.err_count), 32'(m_cnt));
`ifdef LFSR_CHECKER_STICKY_EN
        check("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
        check("led", 32'(bus.led), 32'((m_mode == 2) && !m_sticky));
`else
        check("led", 32'(bus.led), 32'(m_mode == 2));
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input bit b);
        bus.bit_valid = v;
        bus.bit_in    = b;
        @(posedge clk);
        if (v) model_bit(b);
        else   m_pulse = 0;
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic send(input bit v, input bit e);
        bit b;
        if (v) begin
            gen_bit(b);
            b = b ^ e;
        end else begin
            b = 1'($urandom);
        end
        step(v, b);
    endtask

    task automatic do_reset();
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_led", 32'(bus.led), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        int rate;
        rst = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        g = 4'b0001;

        // Clean stream, lock latency, then a single error
        do_reset();
        g = 4'b0001;
        for (int i = 1; i <= 200; i++) begin
            send(1'b1, 1'b0);
            if (i == 18) check("lock_at_18", 32'(bus.locked), 32'd0);
            if (i == 19) check("lock_at_19", 32'(bus.locked), 32'd1);
        end
        check("clean_err_count", 32'(bus.err_count), 32'd0);
        send(1'b1, 1'b1);
        check("single_pulse", 32'(bus.err_pulse), 32'd1);
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        check("single_count", 32'(bus.err_count), 32'd1);
        check("single_locked", 32'(bus.locked), 32'd1);
`ifdef LFSR_CHECKER_STICKY_EN
        check("sticky_set", 32'(bus.err_sticky), 32'd1);
        check("sticky_led", 32'(bus.led), 32'd0);
`endif

        // Four errors inside one window force a relock
        do_reset();
        g = 4'b1010;
        for (int i = 0; i < 19; i++) send(1'b1, 1'b0);
        check("loss_pre_lock", 32'(bus.locked), 32'd1);
        mask = '0;
        while ($countones(mask) < 4) mask[$urandom_range(0, 15)] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, mask[k]);
            if (k == 14) check("loss_in_window", 32'(bus.locked), 32'd1);
        end
        check("loss_unlocked", 32'(bus.locked), 32'd0);
        check("loss_count", 32'(bus.err_count), 32'd4);
        for (int i = 1; i <= 19; i++) begin
            send(1'b1, 1'b0);
            if (i == 18) check("relock_at_18", 32'(bus.locked), 32'd0);
        end
        check("relock_at_19", 32'(bus.locked), 32'd1);
        check("relock_count", 32'(bus.err_count), 32'd4);

        // All-zero input never leaves seeding
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        check("zeros_locked", 32'(bus.locked), 32'd0);
        check("zeros_count", 32'(bus.err_count), 32'd0);

        // Gapped valid, then an asynchronous reset between clock edges
        do_reset();
        g = 4'b0001;
        for (int c = 0; c < 38; c++) send(c % 2 == 0, 1'b0);
        check("gap_lock", 32'(bus.locked), 32'd1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        check("gap_pulse", 32'(bus.err_pulse), 32'd1);
        check("gap_count", 32'(bus.err_count), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_locked", 32'(bus.locked), 32'd0);
        check("async_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("async_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Random valid gaps with alternating sparse and dense error bursts
        do_reset();
        g = 4'($urandom_range(1, 15));
        for (int c = 0; c < 3000; c++) begin
            rate = ((c / 500) % 2 == 1) ? 6 : 60;
            send($urandom_range(0, 3) != 0, $urandom_range(0, rate - 1) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial PRBS receiver and checker for the 4-bit LFSR generator.
- Self-synchronises to an incoming LFSR bit stream, then predicts every following bit locally.
- Counts mismatches and reports lock status on an LED-friendly output.
- Sits at the far end of a board loopback or link, fed by the generator's serial bit.

Parameters:
- WIDTH, 4, LFSR length in bits (min 2).
- TAPS, 4'b1100, feedback mask (x^4+x^3+1); feedback = XOR-reduce(state & TAPS).
- LOCK_COUNT, 15, consecutive correct predictions required before declaring lock.
- WINDOW, 16, valid bits per loss-detection window while locked.
- LOSS_THRESH, 4, mismatches within one window that force loss of lock.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset: all state clears immediately on rst=0; release is synchronous to clk.
- bit_valid  in  1  qualifies bit_in for this cycle.
- bit_in  in  1  received serial LFSR bit.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  CNT_W  saturating count of LOCKED mismatches.
- led  out  1  board status LED.

Behaviour:
- LFSR convention: Fibonacci, left shift.
  - pred = ^(shreg & TAPS).
  - Generator equivalent: next = {s[WIDTH-2:0], fb}; the serial bit is fb.
- All state updates occur only on cycles with bit_valid=1. With bit_valid=0 everything holds, except that err_pulse returns to 0.
- Reset values: state=SEED, shreg=0, seed_cnt=0, match_cnt=0, win_cnt=0, win_err=0, locked=0, err_pulse=0, err_count=0, led=0.
- SEED:
  - shreg <= {shreg[WIDTH-2:0], bit_in}; seed_cnt increments.
  - After WIDTH valid bits, go to VERIFY.
  - If the loaded value is all-zero (illegal lock-up state), stay in SEED, clear seed_cnt and reload.
- VERIFY:
  - Compare bit_in to pred; shreg <= {shreg[WIDTH-2:0], bit_in}.
  - On match: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and clear win_cnt and win_err.
  - On mismatch: clear match_cnt and seed_cnt, go to SEED (the current bit is discarded).
  - No errors are counted in VERIFY.
- LOCKED:
  - shreg <= {shreg[WIDTH-2:0], pred}, i.e. free-running local reference, so single bit errors do not propagate.
  - On mismatch: err_pulse=1 on the following cycle; err_count++ (saturates at all-ones, no wrap); win_err++.
  - win_cnt counts valid bits. At WINDOW bits, evaluate win_err including the current bit:
    - if win_err >= LOSS_THRESH, go to SEED with locked deasserted next cycle; err_count is kept;
    - otherwise clear win_cnt and win_err and stay in LOCKED.
- Latency:
  - locked rises on the cycle after the (WIDTH+LOCK_COUNT)th valid bit, i.e. the 19th by default.
  - err_pulse appears 1 cycle after the errored bit.
- Asserting rst mid-stream aborts immediately; err_count clears.
- led = locked (see optional feature).

Optional Feature:
- Macro: LFSR_CHECKER_STICKY_EN.
- Defined:
  - adds output port err_sticky (1 bit, reset 0);
  - err_sticky sets on any LOCKED mismatch and clears only on reset;
  - led = locked & ~err_sticky.
- Undefined: no err_sticky port; led = locked.

Decomposition:
- Package lfsr_pkg holds:
  - the state enum typedef (SEED, VERIFY, LOCKED);
  - default LFSR constants (WIDTH=4, TAPS=4'b1100), shared with the generator.
- Sub-module lfsr_predict: combinational feedback, pred = ^(state & TAPS), parameterised on WIDTH/TAPS. It is reused by the generator and the checker.
- The FSM and counters stay in lfsr_checker.

Test Plan:
- Clean stream: generator seeded 4'b0001 yields the period-15 sequence 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeating. With bit_valid=1 continuously after reset release, locked=1 on the cycle after the 19th bit; err_count stays 0 over 200 bits; led=1.
- Single error: once locked, invert one bit. Expect exactly one err_pulse, 1 cycle later; err_count=1; locked stays 1; the next bits match again (no propagation).
- Loss of lock: once locked, invert 4 bits within one 16-bit window. Expect locked=0 after that window closes, err_count=4 retained, then relock 19 valid bits later.
- All-zero input: feed 40 zeros. Expect the checker to remain in SEED; locked=0, err_count=0.
- Gapped valid plus reset: toggle bit_valid 1/0 every cycle on a clean stream. Expect locked after 19 valid bits, i.e. about 38 cycles. Then pull rst low mid-window: locked, err_pulse and err_count go to 0 immediately, without waiting for clk.
- With LFSR_CHECKER_STICKY_EN: single error while locked. Expect err_sticky=1 and led=0 while locked=1; the state persists until rst.
